mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the CPU instruction bus (Iw*) and data bus (Dw*). Used when the instruction and data memories are merged into a single unified RAM.
- Sits between the CPU and the unified memory/bus interconnect.
- Accepts one request at a time, runs the memory handshake, and returns read data plus a one-cycle ready pulse to the winning requester.
- Includes a watchdog timeout so a non-responding slave cannot hang the CPU.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I and D buses with a watchdog; define ARB_RR_EN for round-robin ties
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReadEnable,
  input  logic        iIWriteEnable,
  input  logic [3:0]  iIByteEnable,
  input  logic [31:0] iIAddress,
  input  logic [31:0] iIWriteData,
  output logic [31:0] oIReadData,
  output logic        oIReady,
  input  logic        iDReadEnable,
  input  logic        iDWriteEnable,
  input  logic [3:0]  iDByteEnable,
  input  logic [31:0] iDAddress,
  input  logic [31:0] iDWriteData,
  output logic [31:0] oDReadData,
  output logic        oDReady,
  output logic        oMReadEnable,
  output logic        oMWriteEnable,
  output logic [3:0]  oMByteEnable,
  output logic [31:0] oMAddress,
  output logic [31:0] oMWriteData,
  input  logic [31:0] iMReadData,
  input  logic        iMAck,
  output logic        oError,
  output logic        oGrantD
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic        i_req, d_req, win_d, finish;
  logic [31:0] resp;
  assign i_req  = iIReadEnable | iIWriteEnable;
  assign d_req  = iDReadEnable | iDWriteEnable;
  assign finish = iMAck | (cnt == 8'(TIMEOUT - 1));
  assign resp   = iMAck ? iMReadData : ERR_DATA;
`ifdef ARB_RR_EN
  // oGrantD doubles as the last-grant flag: a tie goes to the side not served last
  assign win_d = d_req & (~i_req | ~oGrantD);
`else
  assign win_d = d_req;
`endif
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state         <= IDLE;
      cnt           <= '0;
      oIReadData    <= '0;
      oDReadData    <= '0;
      oIReady       <= 1'b0;
      oDReady       <= 1'b0;
      oMReadEnable  <= 1'b0;
      oMWriteEnable <= 1'b0;
      oMByteEnable  <= '0;
      oMAddress     <= '0;
      oMWriteData   <= '0;
      oError        <= 1'b0;
      oGrantD       <= 1'b0;
    end else begin
      oIReady <= 1'b0;
      oDReady <= 1'b0;
      oError  <= 1'b0;
      case (state)
        IDLE: if (i_req | d_req) begin
          // a request with both strobes set is treated as a write
          oGrantD       <= win_d;
          oMWriteEnable <= win_d ? iDWriteEnable : iIWriteEnable;
          oMReadEnable  <= win_d ? iDReadEnable & ~iDWriteEnable : iIReadEnable & ~iIWriteEnable;
          oMByteEnable  <= win_d ? iDByteEnable : iIByteEnable;
          oMAddress     <= win_d ? iDAddress : iIAddress;
          oMWriteData   <= win_d ? iDWriteData : iIWriteData;
          cnt           <= '0;
          state         <= BUSY;
        end
        BUSY: if (finish) begin
          if (oMReadEnable && oGrantD) oDReadData <= resp;
          if (oMReadEnable && !oGrantD) oIReadData <= resp;
          oError        <= ~iMAck;
          oMReadEnable  <= 1'b0;
          oMWriteEnable <= 1'b0;
          state         <= DONE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          oDReady <= oGrantD;
          oIReady <= ~oGrantD;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for timeout, reset, ties and starvation
module tb_mem_port_arbiter;
  logic        iCLK = 1'b0, iRST = 1'b1;
  logic        iIReadEnable = 1'b0, iIWriteEnable = 1'b0;
  logic [3:0]  iIByteEnable = 4'hF;
  logic [31:0] iIAddress = '0, iIWriteData = 32'h11111111;
  logic [31:0] oIReadData;
  logic        oIReady;
  logic        iDReadEnable = 1'b0, iDWriteEnable = 1'b0;
  logic [3:0]  iDByteEnable = 4'hF;
  logic [31:0] iDAddress = '0, iDWriteData = 32'hCAFEF00D;
  logic [31:0] oDReadData;
  logic        oDReady;
  logic        oMReadEnable, oMWriteEnable;
  logic [3:0]  oMByteEnable;
  logic [31:0] oMAddress, oMWriteData;
  logic [31:0] iMReadData = '0;
  logic        iMAck = 1'b0;
  logic        oError, oGrantD;
  int tests = 0, fails = 0;

  mem_port_arbiter dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReadEnable(iIReadEnable), .iIWriteEnable(iIWriteEnable), .iIByteEnable(iIByteEnable),
    .iIAddress(iIAddress), .iIWriteData(iIWriteData), .oIReadData(oIReadData), .oIReady(oIReady),
    .iDReadEnable(iDReadEnable), .iDWriteEnable(iDWriteEnable), .iDByteEnable(iDByteEnable),
    .iDAddress(iDAddress), .iDWriteData(iDWriteData), .oDReadData(oDReadData), .oDReady(oDReady),
    .oMReadEnable(oMReadEnable), .oMWriteEnable(oMWriteEnable), .oMByteEnable(oMByteEnable),
    .oMAddress(oMAddress), .oMWriteData(oMWriteData), .iMReadData(iMReadData), .iMAck(iMAck),
    .oError(oError), .oGrantD(oGrantD)
  );

  always #5 iCLK = ~iCLK;

  // ctl = {rst, i_re, i_we, d_re, d_we, ack}; flg = {m_re, m_we, i_rdy, d_rdy, grant_d, err}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] iaddr, daddr, mrd;
    logic [5:0]  flg;
    logic [31:0] maddr, ird, drd;
  } vec_t;
  vec_t vecs [13];

  task automatic step;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input logic ire, input logic iwe, input logic [31:0] ia,
                         input logic dre, input logic dwe, input logic [31:0] da);
    iIReadEnable = ire; iIWriteEnable = iwe; iIAddress = ia;
    iDReadEnable = dre; iDWriteEnable = dwe; iDAddress = da;
  endtask

  // one zero-wait transaction from IDLE, ending in the cycle the ready pulse is visible
  task automatic run_txn(input string name, input logic exp_d, input logic [31:0] addr,
                         input logic rd, input logic [31:0] rdata);
    step;
    chk({name, "_grant"}, 128'(oGrantD), 128'(exp_d));
    chk({name, "_addr"}, 128'(oMAddress), 128'(addr));
    chk({name, "_strobe"}, 128'({oMReadEnable, oMWriteEnable}), 128'(rd ? 2'b10 : 2'b01));
    iMAck = 1'b1; iMReadData = rdata;
    step;
    iMAck = 1'b0;
    step;
    chk({name, "_ready"}, 128'({oIReady, oDReady}), 128'(exp_d ? 2'b01 : 2'b10));
    if (rd) chk({name, "_rdata"}, 128'(exp_d ? oDReadData : oIReadData), 128'(rdata));
  endtask

  initial begin
    logic seen;
    int   dcnt;
    vecs[0]  = '{6'b100000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{6'b010000, 32'h00400000, 32'h0, 32'h0, 6'b100000, 32'h00400000, 32'h0, 32'h0};
    vecs[2]  = '{6'b010001, 32'h00400000, 32'h0, 32'h13, 6'b000000, 32'h00400000, 32'h13, 32'h0};
    vecs[3]  = '{6'b010000, 32'h00400000, 32'h0, 32'h0, 6'b001000, 32'h00400000, 32'h13, 32'h0};
    vecs[4]  = '{6'b000000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h00400000, 32'h13, 32'h0};
    vecs[5]  = '{6'b000100, 32'h0, 32'h10010010, 32'h0, 6'b100010, 32'h10010010, 32'h13, 32'h0};
    vecs[6]  = '{6'b000101, 32'h0, 32'h10010010, 32'h12345678, 6'b000010, 32'h10010010, 32'h13, 32'h12345678};
    vecs[7]  = '{6'b000100, 32'h0, 32'h10010010, 32'h0, 6'b000110, 32'h10010010, 32'h13, 32'h12345678};
    vecs[8]  = '{6'b000110, 32'h0, 32'h10010020, 32'h0, 6'b010010, 32'h10010020, 32'h13, 32'h12345678};
    vecs[9]  = '{6'b000111, 32'h0, 32'h10010020, 32'hFFFFFFFF, 6'b000010, 32'h10010020, 32'h13, 32'h12345678};
    vecs[10] = '{6'b000110, 32'h0, 32'h10010020, 32'h0, 6'b000110, 32'h10010020, 32'h13, 32'h12345678};
    vecs[11] = '{6'b000001, 32'h0, 32'h0, 32'hAAAAAAAA, 6'b000010, 32'h10010020, 32'h13, 32'h12345678};
    vecs[12] = '{6'b000000, 32'h0, 32'h0, 32'h0, 6'b000010, 32'h10010020, 32'h13, 32'h12345678};
    @(negedge iCLK);
    for (int i = 0; i < 13; i++) begin
      {iRST, iIReadEnable, iIWriteEnable, iDReadEnable, iDWriteEnable, iMAck} = vecs[i].ctl;
      iIAddress = vecs[i].iaddr; iDAddress = vecs[i].daddr; iMReadData = vecs[i].mrd;
      step;
      chk($sformatf("vec%0d", i),
          128'({oMReadEnable, oMWriteEnable, oIReady, oDReady, oGrantD, oError, oMAddress, oIReadData, oDReadData}),
          128'({vecs[i].flg, vecs[i].maddr, vecs[i].ird, vecs[i].drd}));
    end
    iMAck = 1'b0;

    // watchdog: 16 BUSY cycles, error pulse, then ready with ERR_DATA
    set_req(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10010030);
    step;
    chk("to_start", 128'(oMReadEnable), 128'(1'b1));
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step;
      seen = seen | oError | oDReady;
    end
    chk("to_early", 128'(seen), 128'(1'b0));
    step;
    chk("to_err", 128'({oError, oDReady, oMReadEnable}), 128'(3'b100));
    chk("to_data", 128'(oDReadData), 128'(32'hDEADBEEF));
    step;
    chk("to_ready", 128'({oError, oDReady}), 128'(2'b01));
    set_req(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step;

    // reset while BUSY after two wait cycles
    set_req(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10010050);
    step; step; step;
    iRST = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step;
    chk("rst_mid", 128'({oMReadEnable, oMWriteEnable, oMByteEnable, oMAddress, oMWriteData, oGrantD, oError, oIReady, oDReady, oDReadData}), 128'(0));
    iRST = 1'b0;
    step;
    chk("rst_quiet", 128'({oError, oIReady, oDReady}), 128'(0));
    set_req(1'b1, 1'b0, 32'h00400008, 1'b0, 1'b0, 32'h0);
    run_txn("rst_after", 1'b0, 32'h00400008, 1'b1, 32'h00000077);
    set_req(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // ties from reset: D write against I read
    iRST = 1'b1; step; iRST = 1'b0;
    set_req(1'b1, 1'b0, 32'h00400004, 1'b0, 1'b1, 32'h10010000);
`ifdef ARB_RR_EN
    for (int k = 0; k < 4; k++)
      if (k % 2 == 0) run_txn($sformatf("rr%0d", k), 1'b1, 32'h10010000, 1'b0, 32'h0);
      else run_txn($sformatf("rr%0d", k), 1'b0, 32'h00400004, 1'b1, 32'h00000093 + 32'(k));
`else
    run_txn("tie_d", 1'b1, 32'h10010000, 1'b0, 32'h0);
    chk("tie_wdata", 128'({oMByteEnable, oMWriteData}), 128'({4'hF, 32'hCAFEF00D}));
    iDWriteEnable = 1'b0;
    run_txn("tie_i", 1'b0, 32'h00400004, 1'b1, 32'h00000093);
`endif
    set_req(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step;

`ifndef ARB_RR_EN
    // continuous D traffic starves a held I request
    set_req(1'b1, 1'b0, 32'h0040000C, 1'b1, 1'b0, 32'h10010040);
    iMAck = 1'b1; iMReadData = 32'h0000D00D;
    seen = 1'b0; dcnt = 0;
    for (int n = 0; n < 100 && dcnt < 20; n++) begin
      step;
      seen = seen | oIReady;
      if (oDReady) dcnt++;
    end
    chk("starve_i_ready", 128'(seen), 128'(1'b0));
    chk("starve_d_count", 128'(dcnt), 128'(20));
    iDReadEnable = 1'b0;
    run_txn("starve_i", 1'b0, 32'h0040000C, 1'b1, 32'h0000C0DE);
    set_req(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
